// File: rtl/operand_issue_fifo.sv
// Operand-pair FIFO feeding a fixed-latency downstream pipeline.
// Pairs issue in acceptance order; res_valid_o tracks issue_o delayed by LAT cycles.
module operand_issue_fifo #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LAT    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid_i,
  input  logic [DWIDTH-1:0]        s_op1_i,
  input  logic [DWIDTH-1:0]        s_op2_i,
  output logic                     s_ready_o,
  input  logic                     en_i,
  output logic [DWIDTH-1:0]        op1_o,
  output logic [DWIDTH-1:0]        op2_o,
  output logic                     issue_o,
  output logic                     res_valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DWIDTH-1:0] r_mem_op1 [DEPTH];
  logic [DWIDTH-1:0] r_mem_op2 [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [DWIDTH-1:0] r_op1;
  logic [DWIDTH-1:0] r_op2;
  logic              r_issue;
  logic [LAT-1:0]    r_res_sr;

  logic w_ready;
  logic w_push;
  logic w_pop;

  // Readiness looks only at occupancy, so a full FIFO refuses even while popping.
  assign w_ready = rst && (r_count < CW'(DEPTH));
  assign w_push  = s_valid_i && w_ready;
  assign w_pop   = rst && en_i && (r_count != '0);

  // Pair storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_op1[r_wr_ptr] <= s_op1_i;
      r_mem_op2[r_wr_ptr] <= s_op2_i;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); occupancy disambiguates full/empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Issue register: head pair on a pop, zero bubble otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op1   <= '0;
      r_op2   <= '0;
      r_issue <= 1'b0;
    end else if (w_pop) begin
      r_op1   <= r_mem_op1[r_rd_ptr];
      r_op2   <= r_mem_op2[r_rd_ptr];
      r_issue <= 1'b1;
    end else begin
      r_op1   <= '0;
      r_op2   <= '0;
      r_issue <= 1'b0;
    end
  end

  // Result-valid tracker mirroring the downstream pipeline depth.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_res_sr <= '0;
    end else begin
      r_res_sr <= (r_res_sr << 1) | LAT'(r_issue);
    end
  end

  assign s_ready_o   = w_ready;
  assign op1_o       = r_op1;
  assign op2_o       = r_op2;
  assign issue_o     = r_issue;
  assign res_valid_o = r_res_sr[LAT-1];
  assign count_o     = r_count;

endmodule
